// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS core pipeline: word/register aliases, branch kinds
// and the EX/MEM registered bundle.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BEQ  = 2'd1,
    BR_BNE  = 2'd2
  } branch_t;

  typedef struct packed {
    logic     valid;
    word_t    pc;
    word_t    alu_out;
    word_t    store_data;
    regbits_t wsel;
    logic     regwrite;
    logic     memread;
    logic     memwrite;
    logic     memtoreg;
    logic     halt;
    logic     branch_taken;
    word_t    branch_pc;
  } ex_mem_t;

endpackage

// File: rtl/ex_branch_resolve.sv
// Combinational branch/trap resolution for the instruction leaving EX.
// A trapping instruction never redirects the PC.
module ex_branch_resolve
  import cpu_types_pkg::*;
(
  input  logic    fire_i,
  input  logic    ovf_check_i,
  input  logic    alu_overflow_i,
  input  logic    alu_zero_i,
  input  branch_t branch_type_i,
  output logic    trap_o,
  output logic    taken_o
);

  logic cond_s;

  always_comb begin
    cond_s = 1'b0;
    case (branch_type_i)
      BR_BEQ:  cond_s = alu_zero_i;
      BR_BNE:  cond_s = ~alu_zero_i;
      BR_NONE: cond_s = 1'b0;
      default: cond_s = 1'b0;
    endcase
    trap_o  = fire_i & ovf_check_i & alu_overflow_i;
    taken_o = fire_i & ~trap_o & cond_s;
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU result and control, resolves branches,
// squashes overflowing instructions and keeps a sticky exception with EPC.
module ex_mem_stage
  import cpu_types_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic     CLK,
  input  logic     nRST,
  input  logic     stall,
  input  logic     flush,
  input  logic     ex_valid,
  input  word_t    ex_pc,
  input  word_t    alu_out,
  input  logic     alu_zero,
  input  logic     alu_overflow,
  input  logic     ovf_check,
  input  branch_t  branch_type,
  input  word_t    branch_target,
  input  word_t    store_data,
  input  regbits_t wsel,
  input  logic     regwrite,
  input  logic     memread,
  input  logic     memwrite,
  input  logic     memtoreg,
  input  logic     halt,
  input  logic     exc_clr,
  output logic     mem_valid,
  output word_t    mem_pc,
  output word_t    mem_alu_out,
  output word_t    mem_store_data,
  output regbits_t mem_wsel,
  output logic     mem_regwrite,
  output logic     mem_memread,
  output logic     mem_memwrite,
  output logic     mem_memtoreg,
  output logic     mem_halt,
  output logic     branch_taken,
  output word_t    branch_pc,
  output logic     exc_pending,
  output word_t    epc
);

  ex_mem_t stage_q, stage_d;
  logic    exc_q, exc_d;
  word_t   epc_q, epc_d;
  logic    trap_s, taken_s, live_s;

  ex_branch_resolve u_resolve (
    .fire_i         (ex_valid),
    .ovf_check_i    (ovf_check),
    .alu_overflow_i (alu_overflow),
    .alu_zero_i     (alu_zero),
    .branch_type_i  (branch_type),
    .trap_o         (trap_s),
    .taken_o        (taken_s)
  );

  assign live_s = ex_valid & ~trap_s;

  // Next-state selection: flush > stall > normal load.
  always_comb begin
    stage_d = stage_q;
    exc_d   = exc_q;
    epc_d   = epc_q;
    if (flush) begin
      stage_d.valid        = 1'b0;
      stage_d.regwrite     = 1'b0;
      stage_d.memread      = 1'b0;
      stage_d.memwrite     = 1'b0;
      stage_d.memtoreg     = 1'b0;
      stage_d.halt         = 1'b0;
      stage_d.branch_taken = 1'b0;
      if (exc_clr) exc_d = 1'b0;
      else         exc_d = exc_q;
    end else if (stall) begin
      if (exc_clr) exc_d = 1'b0;
      else         exc_d = exc_q;
    end else begin
      stage_d.valid        = ex_valid;
      stage_d.pc           = ex_pc;
      stage_d.alu_out      = alu_out;
      stage_d.store_data   = store_data;
      stage_d.wsel         = wsel;
      stage_d.regwrite     = live_s & regwrite;
      stage_d.memread      = live_s & memread;
      stage_d.memwrite     = live_s & memwrite;
      stage_d.memtoreg     = ex_valid & memtoreg;
      stage_d.halt         = ex_valid & halt;
      stage_d.branch_taken = taken_s;
      stage_d.branch_pc    = branch_target;
      // A trap beats a same-cycle clear; only a still-pending fault keeps its EPC.
      if (trap_s) begin
        exc_d = 1'b1;
        if (exc_q && !exc_clr) epc_d = epc_q;
        else                   epc_d = ex_pc;
      end else if (exc_clr) begin
        exc_d = 1'b0;
      end else begin
        exc_d = exc_q;
      end
    end
  end

  // Pipeline and exception state flops with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stage_q    <= '0;
      stage_q.pc <= RESET_PC;
      exc_q      <= 1'b0;
      epc_q      <= RESET_PC;
    end else begin
      stage_q <= stage_d;
      exc_q   <= exc_d;
      epc_q   <= epc_d;
    end
  end

  assign mem_valid      = stage_q.valid;
  assign mem_pc         = stage_q.pc;
  assign mem_alu_out    = stage_q.alu_out;
  assign mem_store_data = stage_q.store_data;
  assign mem_wsel       = stage_q.wsel;
  assign mem_regwrite   = stage_q.regwrite;
  assign mem_memread    = stage_q.memread;
  assign mem_memwrite   = stage_q.memwrite;
  assign mem_memtoreg   = stage_q.memtoreg;
  assign mem_halt       = stage_q.halt;
  assign branch_taken   = stage_q.branch_taken;
  assign branch_pc      = stage_q.branch_pc;
  assign exc_pending    = exc_q;
  assign epc            = epc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, overflow trap/EPC, branches, stall,
// flush precedence and exception clear-vs-set.
module tb_ex_mem_stage;
  import cpu_types_pkg::*;

  logic     CLK = 1'b0;
  logic     nRST, stall, flush, ex_valid, alu_zero, alu_overflow, ovf_check;
  word_t    ex_pc, alu_out, branch_target, store_data;
  branch_t  branch_type;
  regbits_t wsel;
  logic     regwrite, memread, memwrite, memtoreg, halt, exc_clr;
  logic     mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg, mem_halt;
  logic     branch_taken, exc_pending;
  word_t    mem_pc, mem_alu_out, mem_store_data, branch_pc, epc;
  regbits_t mem_wsel;

  int total  = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  ex_mem_stage #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .nRST(nRST), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .ovf_check(ovf_check), .branch_type(branch_type), .branch_target(branch_target),
    .store_data(store_data), .wsel(wsel), .regwrite(regwrite), .memread(memread),
    .memwrite(memwrite), .memtoreg(memtoreg), .halt(halt), .exc_clr(exc_clr),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_alu_out(mem_alu_out),
    .mem_store_data(mem_store_data), .mem_wsel(mem_wsel), .mem_regwrite(mem_regwrite),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg),
    .mem_halt(mem_halt), .branch_taken(branch_taken), .branch_pc(branch_pc),
    .exc_pending(exc_pending), .epc(epc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_pc = 32'h0; alu_out = 32'h0;
    alu_zero = 1'b0; alu_overflow = 1'b0; ovf_check = 1'b0; branch_type = BR_NONE;
    branch_target = 32'h0; store_data = 32'h0; wsel = 5'd0; regwrite = 1'b0;
    memread = 1'b0; memwrite = 1'b0; memtoreg = 1'b0; halt = 1'b0; exc_clr = 1'b0;
  endtask

  initial begin
    // Reset with a valid trapping ADD presented.
    idle_inputs();
    nRST = 1'b0; ex_valid = 1'b1; ex_pc = 32'h40; alu_out = 32'h55; regwrite = 1'b1;
    ovf_check = 1'b1; alu_overflow = 1'b1; wsel = 5'd3;
    tick(); tick();
    chk("rst_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_regwrite", {31'd0, mem_regwrite}, 32'd0);
    chk("rst_pc", mem_pc, 32'h0);
    chk("rst_alu", mem_alu_out, 32'h0);
    chk("rst_exc", {31'd0, exc_pending}, 32'd0);
    chk("rst_epc", epc, 32'h0);

    // Overflow trap at 0x40; halt passes since it is gated only by ex_valid.
    nRST = 1'b1; alu_out = 32'h1234; halt = 1'b1;
    tick();
    chk("trap_regwrite", {31'd0, mem_regwrite}, 32'd0);
    chk("trap_valid", {31'd0, mem_valid}, 32'd1);
    chk("trap_halt", {31'd0, mem_halt}, 32'd1);
    chk("trap_exc", {31'd0, exc_pending}, 32'd1);
    chk("trap_epc", epc, 32'h40);
    chk("trap_alu", mem_alu_out, 32'h1234);
    chk("trap_wsel", {27'd0, mem_wsel}, 32'd3);

    // Second trap keeps the first EPC.
    halt = 1'b0; ex_pc = 32'h44;
    tick();
    chk("trap2_epc", epc, 32'h40);
    chk("trap2_pc", mem_pc, 32'h44);

    // Clear alone with a bubble.
    ex_valid = 1'b0; exc_clr = 1'b1;
    tick();
    chk("clr_exc", {31'd0, exc_pending}, 32'd0);
    chk("clr_epc", epc, 32'h40);
    chk("bubble_valid", {31'd0, mem_valid}, 32'd0);

    // ADDU with overflow but no check: writes, no exception.
    exc_clr = 1'b0; ex_valid = 1'b1; ex_pc = 32'h48; ovf_check = 1'b0;
    tick();
    chk("addu_regwrite", {31'd0, mem_regwrite}, 32'd1);
    chk("addu_exc", {31'd0, exc_pending}, 32'd0);

    // BEQ taken.
    alu_overflow = 1'b0; regwrite = 1'b0; branch_type = BR_BEQ; alu_zero = 1'b1;
    branch_target = 32'h100;
    tick();
    chk("beq_taken", {31'd0, branch_taken}, 32'd1);
    chk("beq_pc", branch_pc, 32'h100);

    // BNE with zero set: not taken.
    branch_type = BR_BNE;
    tick();
    chk("bne_taken", {31'd0, branch_taken}, 32'd0);

    // BNE with zero clear: taken.
    alu_zero = 1'b0; branch_target = 32'h200;
    tick();
    chk("bne_nz_taken", {31'd0, branch_taken}, 32'd1);
    chk("bne_nz_pc", branch_pc, 32'h200);

    // BEQ with no valid instruction.
    branch_type = BR_BEQ; alu_zero = 1'b1; ex_valid = 1'b0;
    tick();
    chk("beq_invalid", {31'd0, branch_taken}, 32'd0);

    // SW then stall three cycles with changing inputs (including a would-be trap).
    branch_type = BR_NONE; alu_zero = 1'b0; ex_valid = 1'b1; ex_pc = 32'h50;
    memwrite = 1'b1; store_data = 32'hDEADBEEF;
    tick();
    chk("sw_data", mem_store_data, 32'hDEADBEEF);
    chk("sw_memwrite", {31'd0, mem_memwrite}, 32'd1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      store_data = 32'h1111_0000 + i; memwrite = 1'b0; ex_pc = 32'h60 + 4 * i;
      ovf_check = 1'b1; alu_overflow = 1'b1;
      tick();
      chk("stall_data", mem_store_data, 32'hDEADBEEF);
      chk("stall_memwrite", {31'd0, mem_memwrite}, 32'd1);
      chk("stall_pc", mem_pc, 32'h50);
    end
    chk("stall_exc", {31'd0, exc_pending}, 32'd0);

    // Flush wins over stall with a valid LW.
    ovf_check = 1'b0; alu_overflow = 1'b0; flush = 1'b1; memread = 1'b1; memtoreg = 1'b1;
    tick();
    chk("flush_valid", {31'd0, mem_valid}, 32'd0);
    chk("flush_memread", {31'd0, mem_memread}, 32'd0);
    chk("flush_memwrite", {31'd0, mem_memwrite}, 32'd0);

    // Trap at 0x60, then flush leaves exception state alone.
    flush = 1'b0; stall = 1'b0; memread = 1'b0; memtoreg = 1'b0; ex_pc = 32'h60;
    ovf_check = 1'b1; alu_overflow = 1'b1; regwrite = 1'b1;
    tick();
    chk("trap60_epc", epc, 32'h60);
    flush = 1'b1; ex_pc = 32'h64;
    tick();
    chk("flush_exc", {31'd0, exc_pending}, 32'd1);
    chk("flush_epc", epc, 32'h60);

    // Clear and trap together: trap wins with the new PC.
    flush = 1'b0; exc_clr = 1'b1; ex_pc = 32'h80;
    tick();
    chk("clrset_exc", {31'd0, exc_pending}, 32'd1);
    chk("clrset_epc", epc, 32'h80);
    ovf_check = 1'b0; alu_overflow = 1'b0; ex_valid = 1'b0;
    tick();
    chk("clr2_exc", {31'd0, exc_pending}, 32'd0);
    chk("clr2_epc", epc, 32'h80);

    // Reset during stall still resets.
    exc_clr = 1'b0; ex_valid = 1'b1; ex_pc = 32'h90; regwrite = 1'b1;
    tick();
    chk("pre_rst_valid", {31'd0, mem_valid}, 32'd1);
    stall = 1'b1; nRST = 1'b0;
    tick();
    chk("rst_stall_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_stall_pc", mem_pc, 32'h0);
    chk("rst_stall_epc", epc, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
